// File: rtl/sys_array_sequencer.sv
// Systolic-array job sequencer: loads weights, streams data-matrix rows
// into the array with per-lane skew, and tracks result rows to completion.
module sys_array_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ARRAY_A_W  = 5,
   parameter int ARRAY_A_L  = 3,
   parameter int OUT_LAT    = 4,
   localparam int RW = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic                            weights_load,
   output logic                            a_rd_en,
   output logic [RW-1:0]                   a_rd_row,
   input  logic [ARRAY_A_L*DATA_WIDTH-1:0] a_rd_data,
   output logic [ARRAY_A_L*DATA_WIDTH-1:0] feed_data,
   output logic [ARRAY_A_L-1:0]            feed_valid,
   output logic                            result_valid,
   output logic [RW-1:0]                   result_row
);

   // Row tracker depth: lane skew plus array output latency.
   localparam int P = ARRAY_A_L + OUT_LAT;
   localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_A_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GAP,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic          r_busy;
   logic          r_done;
   logic          r_wl;
   logic          r_rd_en;
   logic [RW-1:0] r_rd_row;

   // Stage s holds the valid flag / row tag of the row whose
   // lane-0 element was fed s cycles ago.
   logic [P-1:0]  r_pv;
   logic [RW-1:0] r_prow [P];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; the job ends one cycle after the last result row.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  w_next = S_GAP;
         S_GAP:   w_next = S_FEED;
         S_FEED:  if (r_rd_row == LAST_ROW) w_next = S_DRAIN;
         S_DRAIN: if (r_pv[P-1] && (r_prow[P-1] == LAST_ROW)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Control outputs registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wl     <= 1'b0;
         r_rd_en  <= 1'b0;
         r_rd_row <= '0;
      end else begin
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         r_wl    <= (w_next == S_LOAD);
         r_rd_en <= (w_next == S_FEED);
         if ((w_next == S_FEED) && (r_state == S_FEED)) begin
            r_rd_row <= r_rd_row + RW'(1);
         end else begin
            r_rd_row <= '0;
         end
      end
   end

   // Row tracker: read strobe delayed by one for the data return, then
   // shifted along the lane skew and output latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pv <= '0;
         for (int s = 0; s < P; s++) begin
            r_prow[s] <= '0;
         end
      end else begin
         r_pv[0]   <= r_rd_en;
         r_prow[0] <= r_rd_row;
         for (int s = 1; s < P; s++) begin
            r_pv[s]   <= r_pv[s-1];
            r_prow[s] <= r_prow[s-1];
         end
      end
   end

   // Lane k gets a k-deep delay line; lane 0 passes the returned row
   // straight through in the cycle it arrives.
   for (genvar k = 0; k < ARRAY_A_L; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_in;
      logic [DATA_WIDTH-1:0] w_lane;

      assign w_in = a_rd_data[k*DATA_WIDTH +: DATA_WIDTH];

      if (k == 0) begin : g_pass
         assign w_lane = w_in;
      end else begin : g_skew
         logic [DATA_WIDTH-1:0] r_sk [k];

         // Skew shift register for this lane.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int j = 0; j < k; j++) begin
                  r_sk[j] <= '0;
               end
            end else begin
               r_sk[0] <= w_in;
               for (int j = 1; j < k; j++) begin
                  r_sk[j] <= r_sk[j-1];
               end
            end
         end

         assign w_lane = r_sk[k-1];
      end

      assign feed_data[k*DATA_WIDTH +: DATA_WIDTH] =
         r_pv[k] ? w_lane : '0;
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign weights_load = r_wl;
   assign a_rd_en      = r_rd_en;
   assign a_rd_row     = r_rd_row;
   assign feed_valid   = r_pv[ARRAY_A_L-1:0];
   assign result_valid = r_pv[P-1];
   assign result_row   = r_prow[P-1];

endmodule
